inst_sram_ctrl: RTL and testbench
=================================

Name: inst_sram_ctrl

Overview:
- Instruction-side SRAM bus controller directly downstream of the PC stage.
- Consumes the PC stage's address/ce/rom_op/wr_data request and runs multi-cycle read or write cycles on the external base SRAM.
- Returns the fetched instruction to the IF/ID boundary and raises a stall request while a bus cycle is in flight.
- Writes are the store path that the PC stage muxes onto the instruction bus; they complete with a NOP presented to IF/ID.

Parameters:
ADDR_W, 20, SRAM word-address width; sram_addr = addr_i[ADDR_W+1:2]
READ_WAIT, 1, cycles OE/CE held low before data is sampled (>=1)
WRITE_WAIT, 1, cycles WE held low (>=1)

Ports:
clk  in  1  system clock, all state on posedge
rst  in  1  synchronous reset, active-low
ce_i  in  1  request valid from PC stage
rom_op_i  in  1  0 = read (fetch), 1 = write
addr_i  in  32  byte address; bits [1:0] ignored
wr_data_i  in  32  write data
flush_i  in  1  pipeline flush
stall_if_i  in  1  IF/ID stalled; hold the presented result
inst_o  out  32  fetched instruction, NOP (0) when none
inst_valid_o  out  1  inst_o carries a real fetched word this cycle
stallreq_o  out  1  stall request to pipeline control (combinational)
sram_addr_o  out  ADDR_W  SRAM word address
sram_data_o  out  32  write data to SRAM pads
sram_data_i  in  32  read data from SRAM pads
sram_data_oe  out  1  drive sram_data_o onto the bus
sram_ce_n  out  1  chip enable, active-low
sram_oe_n  out  1  output enable, active-low
sram_we_n  out  1  write enable, active-low
sram_be_n  out  4  byte enables, active-low; always 4'b0000 when ce_n=0

Behaviour:
- Reset (rst=0 at posedge), taking priority over everything, including mid-cycle: state=IDLE, sram_ce_n/oe_n/we_n=1, sram_be_n=4'b1111, sram_data_oe=0, sram_addr_o=0, sram_data_o=0, inst_o=0, inst_valid_o=0. Strobes deassert on that same edge.
- States: IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, DONE. A wait counter is used in RD and WR_PULSE.
- All SRAM outputs, inst_o and inst_valid_o are registered.
- stallreq_o is combinational:
  - 1 when state==IDLE and ce_i=1 and flush_i=0.
  - 1 in RD, WR_SETUP, WR_PULSE and WR_HOLD.
  - 0 in DONE and otherwise.
- IDLE:
  - ce_i=0 or flush_i=1: stay in IDLE; inst_o=0, inst_valid_o=0.
  - Read request: latch address, ce_n=0, oe_n=0, be_n=0000, go to RD with counter=READ_WAIT.
  - Write request: latch address and data, data_oe=1, ce_n=0, we_n=1, be_n=0000, go to WR_SETUP.
- RD:
  - Decrement the counter each cycle.
  - On the edge where the counter reaches 0: sample sram_data_i into inst_o, set inst_valid_o=1, set ce_n=oe_n=1, go to DONE.
  - Read latency: request seen in IDLE -> inst_o valid after READ_WAIT+1 edges. With READ_WAIT=1, stallreq_o is high for 2 cycles.
- WR_SETUP: 1 cycle, then we_n=0, counter=WRITE_WAIT, go to WR_PULSE.
- WR_PULSE: on counter 0, we_n=1, go to WR_HOLD. ce_n stays 0 and the data stays driven.
- WR_HOLD: 1 cycle, then ce_n=1, data_oe=0, inst_o=0, inst_valid_o=0, go to DONE. Total write time is WRITE_WAIT+3 edges to DONE.
- sram_addr_o and sram_data_o stay stable from entry to exit of any bus cycle (no glitch while ce_n=0).
- DONE:
  - stall_if_i=1: remain in DONE holding inst_o and inst_valid_o.
  - Otherwise go to IDLE; inst_o and inst_valid_o stay as-is for this edge and then follow IDLE rules.
- Flush:
  - During RD: the bus cycle completes unchanged, but DONE presents inst_o=0, inst_valid_o=0 (sticky flush flag cleared on leaving DONE).
  - During any write state: ignored; the write always completes. Writes are never aborted except by reset.
  - In DONE: inst_o forced to 0 and inst_valid_o to 0 on the next edge.
- Back-to-back requests: a new request is accepted only in IDLE. Minimum read throughput is one fetch per READ_WAIT+2 cycles.
- Inputs are ignored while not in IDLE (the PC stage is stalled by stallreq_o).

Test Plan:
- Reset, then read 0x80000004 with the SRAM model returning 0x24010001 -> sram_addr_o=0x00001; ce_n and oe_n low exactly 1 cycle; stallreq_o high 2 cycles; inst_o=0x24010001 with inst_valid_o=1 in DONE.
- Write 0xDEADBEEF to 0x80000010 (WRITE_WAIT=1) -> sram_addr_o=0x00004; data_oe high 3 cycles; we_n low exactly 1 cycle in the middle; model memory holds 0xDEADBEEF; DONE presents inst_o=0, inst_valid_o=0.
- flush_i pulsed during RD of 0x80000008 (model word 0x3C1D8040) -> bus cycle completes; DONE shows inst_o=0, inst_valid_o=0.
- stall_if_i=1 for 3 cycles at DONE after fetch 0x00000021 -> inst_o holds 0x00000021 all 3 cycles; the next request is accepted only after release.
- rst driven low while in WR_PULSE -> on the next edge we_n=1, ce_n=1, data_oe=0, state IDLE, stallreq_o=0.
- Two consecutive reads with READ_WAIT=2 -> each takes 4 cycles; stallreq_o high 3 cycles per fetch; sram_addr_o stable while ce_n=0.

Source files
------------

// File: rtl/inst_sram_ctrl.sv
// Instruction-side SRAM bus controller.
// Turns PC-stage fetch/store requests into multi-cycle cycles on the external
// base SRAM, returns the fetched word to IF/ID and stalls the pipeline while
// a bus cycle is in flight. Every pad-facing signal is registered.
module inst_sram_ctrl #(
  parameter int ADDR_W     = 20,
  parameter int READ_WAIT  = 1,
  parameter int WRITE_WAIT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce_i,
  input  logic              rom_op_i,
  input  logic [31:0]       addr_i,
  input  logic [31:0]       wr_data_i,
  input  logic              flush_i,
  input  logic              stall_if_i,
  output logic [31:0]       inst_o,
  output logic              inst_valid_o,
  output logic              stallreq_o,
  output logic [ADDR_W-1:0] sram_addr_o,
  output logic [31:0]       sram_data_o,
  input  logic [31:0]       sram_data_i,
  output logic              sram_data_oe,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic [3:0]        sram_be_n
);

  localparam int MAX_WAIT = (READ_WAIT > WRITE_WAIT) ? READ_WAIT : WRITE_WAIT;
  localparam int CNT_W    = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_WR_SETUP, S_WR_PULSE, S_WR_HOLD, S_DONE
  } state_t;

  state_t            r_state,    w_state_nxt;
  logic [CNT_W-1:0]  r_cnt,      w_cnt_nxt;
  logic              r_flush,    w_flush_nxt;
  logic [31:0]       r_inst,     w_inst_nxt;
  logic              r_inst_vld, w_inst_vld_nxt;
  logic [ADDR_W-1:0] r_addr,     w_addr_nxt;
  logic [31:0]       r_wdata,    w_wdata_nxt;
  logic              r_data_oe,  w_data_oe_nxt;
  logic              r_ce_n,     w_ce_n_nxt;
  logic              r_oe_n,     w_oe_n_nxt;
  logic              r_we_n,     w_we_n_nxt;
  logic [3:0]        r_be_n,     w_be_n_nxt;
  logic              w_stallreq;
  logic              w_rd_flushed;
  logic              w_unused;

  // Only the word-address bits reach the pads; byte offset and high bits are dropped.
  assign w_unused = ^addr_i;

  // State and registered outputs; reset idles the bus on the same edge, even mid-cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_flush    <= 1'b0;
      r_inst     <= '0;
      r_inst_vld <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_data_oe  <= 1'b0;
      r_ce_n     <= 1'b1;
      r_oe_n     <= 1'b1;
      r_we_n     <= 1'b1;
      r_be_n     <= 4'b1111;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_flush    <= w_flush_nxt;
      r_inst     <= w_inst_nxt;
      r_inst_vld <= w_inst_vld_nxt;
      r_addr     <= w_addr_nxt;
      r_wdata    <= w_wdata_nxt;
      r_data_oe  <= w_data_oe_nxt;
      r_ce_n     <= w_ce_n_nxt;
      r_oe_n     <= w_oe_n_nxt;
      r_we_n     <= w_we_n_nxt;
      r_be_n     <= w_be_n_nxt;
    end
  end

  // Next-state, next-output and stall-request decode.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_flush_nxt    = r_flush;
    w_inst_nxt     = r_inst;
    w_inst_vld_nxt = r_inst_vld;
    w_addr_nxt     = r_addr;
    w_wdata_nxt    = r_wdata;
    w_data_oe_nxt  = r_data_oe;
    w_ce_n_nxt     = r_ce_n;
    w_oe_n_nxt     = r_oe_n;
    w_we_n_nxt     = r_we_n;
    w_be_n_nxt     = r_be_n;
    w_stallreq     = 1'b0;
    w_rd_flushed   = flush_i | r_flush;

    case (r_state)
      S_IDLE: begin
        w_inst_nxt     = '0;
        w_inst_vld_nxt = 1'b0;
        if (ce_i && !flush_i) begin
          w_stallreq = 1'b1;
          w_addr_nxt = addr_i[ADDR_W+1:2];
          w_ce_n_nxt = 1'b0;
          w_be_n_nxt = 4'b0000;
          if (!rom_op_i) begin
            w_oe_n_nxt  = 1'b0;
            w_cnt_nxt   = CNT_W'(READ_WAIT);
            w_state_nxt = S_RD;
          end else begin
            w_wdata_nxt   = wr_data_i;
            w_data_oe_nxt = 1'b1;
            w_we_n_nxt    = 1'b1;
            w_state_nxt   = S_WR_SETUP;
          end
        end
      end
      S_RD: begin
        w_stallreq = 1'b1;
        if (flush_i) w_flush_nxt = 1'b1;
        if (r_cnt <= CNT_W'(1)) begin
          // A flush seen at any point of the read suppresses the result, not the bus cycle.
          w_inst_nxt     = w_rd_flushed ? 32'h0 : sram_data_i;
          w_inst_vld_nxt = !w_rd_flushed;
          w_ce_n_nxt     = 1'b1;
          w_oe_n_nxt     = 1'b1;
          w_be_n_nxt     = 4'b1111;
          w_cnt_nxt      = '0;
          w_state_nxt    = S_DONE;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      S_WR_SETUP: begin
        w_stallreq  = 1'b1;
        w_we_n_nxt  = 1'b0;
        w_cnt_nxt   = CNT_W'(WRITE_WAIT);
        w_state_nxt = S_WR_PULSE;
      end
      S_WR_PULSE: begin
        w_stallreq = 1'b1;
        if (r_cnt <= CNT_W'(1)) begin
          w_we_n_nxt  = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = S_WR_HOLD;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      S_WR_HOLD: begin
        w_stallreq     = 1'b1;
        w_ce_n_nxt     = 1'b1;
        w_be_n_nxt     = 4'b1111;
        w_data_oe_nxt  = 1'b0;
        w_inst_nxt     = '0;
        w_inst_vld_nxt = 1'b0;
        w_state_nxt    = S_DONE;
      end
      S_DONE: begin
        if (flush_i) begin
          w_inst_nxt     = '0;
          w_inst_vld_nxt = 1'b0;
        end
        if (!stall_if_i) begin
          w_flush_nxt = 1'b0;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign stallreq_o   = w_stallreq;
  assign inst_o       = r_inst;
  assign inst_valid_o = r_inst_vld;
  assign sram_addr_o  = r_addr;
  assign sram_data_o  = r_wdata;
  assign sram_data_oe = r_data_oe;
  assign sram_ce_n    = r_ce_n;
  assign sram_oe_n    = r_oe_n;
  assign sram_we_n    = r_we_n;
  assign sram_be_n    = r_be_n;

endmodule

// File: tb/tb_inst_sram_ctrl.sv
// Bench for inst_sram_ctrl: two instances (READ_WAIT/WRITE_WAIT = 1/1 and 2/3),
// each with its own SRAM model, driven by a directed table, hand sequences and
// random transactions checked against a transaction-level reference memory.
module tb_inst_sram_ctrl;

  logic        clk;
  logic        rst;
  logic        ce [2];
  logic        op [2];
  logic        fl [2];
  logic        st [2];
  logic [31:0] addr [2];
  logic [31:0] wd [2];
  logic [31:0] sdi [2];
  logic [31:0] inst [2];
  logic        vld [2];
  logic        sreq [2];
  logic [19:0] saddr [2];
  logic [31:0] sdo [2];
  logic        doe [2];
  logic        cen [2];
  logic        oen [2];
  logic        wen [2];
  logic [3:0]  ben [2];

  logic [31:0] mem [2][1024];
  logic [31:0] ref_mem [2][1024];
  logic        pl_we;
  logic [9:0]  pl_a;
  logic [31:0] pl_d;

  int n_vec;
  int n_err;

  typedef struct {
    int          d;
    bit          wr;
    logic [31:0] a;
    logic [31:0] wdat;
    int          fl_cyc;
    int          stall_n;
    bit          done_fl;
    logic [31:0] e_inst;
    bit          e_vld;
    logic [19:0] e_saddr;
  } vec_t;

  vec_t tbl [15];

  inst_sram_ctrl #(.ADDR_W(20), .READ_WAIT(1), .WRITE_WAIT(1)) u_dut0 (
    .clk(clk), .rst(rst), .ce_i(ce[0]), .rom_op_i(op[0]), .addr_i(addr[0]),
    .wr_data_i(wd[0]), .flush_i(fl[0]), .stall_if_i(st[0]), .inst_o(inst[0]),
    .inst_valid_o(vld[0]), .stallreq_o(sreq[0]), .sram_addr_o(saddr[0]),
    .sram_data_o(sdo[0]), .sram_data_i(sdi[0]), .sram_data_oe(doe[0]),
    .sram_ce_n(cen[0]), .sram_oe_n(oen[0]), .sram_we_n(wen[0]), .sram_be_n(ben[0])
  );

  inst_sram_ctrl #(.ADDR_W(20), .READ_WAIT(2), .WRITE_WAIT(3)) u_dut1 (
    .clk(clk), .rst(rst), .ce_i(ce[1]), .rom_op_i(op[1]), .addr_i(addr[1]),
    .wr_data_i(wd[1]), .flush_i(fl[1]), .stall_if_i(st[1]), .inst_o(inst[1]),
    .inst_valid_o(vld[1]), .stallreq_o(sreq[1]), .sram_addr_o(saddr[1]),
    .sram_data_o(sdo[1]), .sram_data_i(sdi[1]), .sram_data_oe(doe[1]),
    .sram_ce_n(cen[1]), .sram_oe_n(oen[1]), .sram_we_n(wen[1]), .sram_be_n(ben[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Asynchronous-read SRAM: drives the array word only while CE and OE are low.
  always_comb begin
    for (int d = 0; d < 2; d++)
      sdi[d] = (!cen[d] && !oen[d]) ? mem[d][saddr[d][9:0]] : 32'hBAD0_BAD0;
  end

  // SRAM write port plus a preload port used while the controllers sit in reset.
  always @(posedge clk) begin
    if (pl_we) begin
      mem[0][pl_a] <= pl_d;
      mem[1][pl_a] <= pl_d;
    end
    for (int d = 0; d < 2; d++)
      if (!cen[d] && !wen[d] && doe[d]) mem[d][saddr[d][9:0]] <= sdo[d];
  end

  function automatic int rw(input int d);
    return (d == 0) ? 1 : 2;
  endfunction

  function automatic int ww(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  function automatic logic [8:0] ctl(input int d);
    return {sreq[d], cen[d], oen[d], wen[d], doe[d], ben[d]};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  // One complete bus transaction on instance d, with optional flush during the
  // bus cycle, stall cycles in DONE and a flush in DONE. Inputs other than
  // flush/stall are scrambled while the controller is busy: they must be ignored.
  task automatic xact(input int d, input bit wr, input logic [31:0] a,
                      input logic [31:0] wdat, input int fl_cyc, input int stall_n,
                      input bit done_fl, input logic [31:0] e_inst, input bit e_vld,
                      input logic [19:0] e_saddr);
    int          busy;
    int          idx;
    logic        e_wen;
    logic [31:0] shown;
    busy = wr ? ww(d) + 2 : rw(d);
    idx  = int'((a >> 2) % 1024);
    ce[d] = 1'b1; op[d] = wr; addr[d] = a; wd[d] = wdat; fl[d] = 1'b0; st[d] = 1'b0;
    #1;
    chk($sformatf("d%0d req stallreq", d), {31'h0, sreq[d]}, 32'h1);
    cyc();
    for (int k = 0; k < busy; k++) begin
      ce[d] = 1'($urandom); op[d] = 1'($urandom); addr[d] = $urandom; wd[d] = $urandom;
      fl[d] = (k == fl_cyc);
      #1;
      e_wen = !(wr && k >= 1 && k <= ww(d));
      if (wr)
        chk($sformatf("d%0d wr cyc%0d ctl", d, k), {23'h0, ctl(d)}, {23'h0, 1'b1, 1'b0, 1'b1, e_wen, 1'b1, 4'h0});
      else
        chk($sformatf("d%0d rd cyc%0d ctl", d, k), {23'h0, ctl(d)}, {23'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0});
      chk($sformatf("d%0d cyc%0d addr", d, k), {12'h0, saddr[d]}, {12'h0, e_saddr});
      if (wr) chk($sformatf("d%0d cyc%0d wdata", d, k), sdo[d], wdat);
      cyc();
    end
    fl[d] = 1'b0;
    for (int j = 0; j <= stall_n; j++) begin
      st[d] = (j < stall_n);
      fl[d] = done_fl && (j == 0);
      ce[d] = 1'($urandom); op[d] = 1'($urandom); addr[d] = $urandom;
      #1;
      shown = (done_fl && j > 0) ? 32'h0 : e_inst;
      chk($sformatf("d%0d done%0d ctl", d, j), {23'h0, ctl(d)}, {23'h0, 9'b0_1110_1111});
      chk($sformatf("d%0d done%0d inst", d, j), inst[d], shown);
      chk($sformatf("d%0d done%0d valid", d, j), {31'h0, vld[d]},
          {31'h0, (done_fl && j > 0) ? 1'b0 : e_vld});
      cyc();
    end
    st[d] = 1'b0; fl[d] = 1'b0; ce[d] = 1'b0;
    #1;
    chk($sformatf("d%0d idle inst", d), inst[d], done_fl ? 32'h0 : e_inst);
    chk($sformatf("d%0d idle valid", d), {31'h0, vld[d]}, {31'h0, done_fl ? 1'b0 : e_vld});
    if (wr) chk($sformatf("d%0d sram word", d), mem[d][idx], wdat);
  endtask

  initial begin
    int          d;
    bit          wr;
    logic [31:0] a;
    logic [31:0] w;
    int          busy;
    int          fc;
    int          sn;
    bit          dfl;
    int          idx;
    logic [31:0] v;

    n_vec = 0; n_err = 0;
    rst = 1'b0; pl_we = 1'b0; pl_a = '0; pl_d = '0;
    for (int i = 0; i < 2; i++) begin
      ce[i] = 1'b0; op[i] = 1'b0; fl[i] = 1'b0; st[i] = 1'b0; addr[i] = '0; wd[i] = '0;
    end

    tbl[0]  = '{0, 1'b0, 32'h8000_0004, 32'h0,         -1, 0, 1'b0, 32'h2401_0001, 1'b1, 20'h00001};
    tbl[1]  = '{0, 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, -1, 0, 1'b0, 32'h0,         1'b0, 20'h00004};
    tbl[2]  = '{0, 1'b0, 32'h8000_0010, 32'h0,         -1, 0, 1'b0, 32'hDEAD_BEEF, 1'b1, 20'h00004};
    tbl[3]  = '{0, 1'b0, 32'h8000_0008, 32'h0,          0, 0, 1'b0, 32'h0,         1'b0, 20'h00002};
    tbl[4]  = '{0, 1'b0, 32'h8000_0008, 32'h0,         -1, 0, 1'b0, 32'h3C1D_8040, 1'b1, 20'h00002};
    tbl[5]  = '{0, 1'b0, 32'h8000_000C, 32'h0,         -1, 3, 1'b0, 32'h0000_0021, 1'b1, 20'h00003};
    tbl[6]  = '{0, 1'b0, 32'h8000_0004, 32'h0,         -1, 2, 1'b1, 32'h2401_0001, 1'b1, 20'h00001};
    tbl[7]  = '{0, 1'b1, 32'h8000_0014, 32'hA5A5_5A5A,  1, 0, 1'b0, 32'h0,         1'b0, 20'h00005};
    tbl[8]  = '{0, 1'b0, 32'h8000_0017, 32'h0,         -1, 0, 1'b0, 32'hA5A5_5A5A, 1'b1, 20'h00005};
    tbl[9]  = '{1, 1'b0, 32'h8000_0004, 32'h0,         -1, 0, 1'b0, 32'h2401_0001, 1'b1, 20'h00001};
    tbl[10] = '{1, 1'b0, 32'h8000_0008, 32'h0,         -1, 0, 1'b0, 32'h3C1D_8040, 1'b1, 20'h00002};
    tbl[11] = '{1, 1'b1, 32'h8000_0FFC, 32'h1234_5678,  4, 1, 1'b0, 32'h0,         1'b0, 20'h003FF};
    tbl[12] = '{1, 1'b0, 32'h8000_0FFC, 32'h0,          1, 0, 1'b0, 32'h0,         1'b0, 20'h003FF};
    tbl[13] = '{1, 1'b0, 32'h8000_0FFE, 32'h0,         -1, 0, 1'b0, 32'h1234_5678, 1'b1, 20'h003FF};
    tbl[14] = '{0, 1'b0, 32'h7FFF_FFF0, 32'h0,         -1, 0, 1'b0, 32'hCAFE_0001, 1'b1, 20'hFFFFC};

    // Reset held while both SRAM models are preloaded.
    cyc(); cyc();
    for (int i = 0; i < 1024; i++) begin
      case (i)
        1:       v = 32'h2401_0001;
        2:       v = 32'h3C1D_8040;
        3:       v = 32'h0000_0021;
        'h3FC:   v = 32'hCAFE_0001;
        default: v = $urandom;
      endcase
      ref_mem[0][i] = v; ref_mem[1][i] = v;
      pl_a = 10'(i); pl_d = v; pl_we = 1'b1;
      cyc();
    end
    pl_we = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("d%0d reset ctl", i), {23'h0, ctl(i)}, {23'h0, 9'b0_1110_1111});
      chk($sformatf("d%0d reset inst", i), inst[i], 32'h0);
      chk($sformatf("d%0d reset valid", i), {31'h0, vld[i]}, 32'h0);
      chk($sformatf("d%0d reset addr", i), {12'h0, saddr[i]}, 32'h0);
      chk($sformatf("d%0d reset wdata", i), sdo[i], 32'h0);
    end
    rst = 1'b1;
    cyc();

    // Directed table.
    for (int t = 0; t < 15; t++) begin
      xact(tbl[t].d, tbl[t].wr, tbl[t].a, tbl[t].wdat, tbl[t].fl_cyc, tbl[t].stall_n,
           tbl[t].done_fl, tbl[t].e_inst, tbl[t].e_vld, tbl[t].e_saddr);
      if (tbl[t].wr) ref_mem[tbl[t].d][int'((tbl[t].a >> 2) % 1024)] = tbl[t].wdat;
    end

    // A request together with flush in IDLE is not accepted.
    ce[0] = 1'b1; op[0] = 1'b0; addr[0] = 32'h8000_0004; fl[0] = 1'b1;
    #1;
    chk("idle flush stallreq", {31'h0, sreq[0]}, 32'h0);
    cyc();
    ce[0] = 1'b0; fl[0] = 1'b0;
    #1;
    chk("idle flush ctl", {23'h0, ctl(0)}, {23'h0, 9'b0_1110_1111});
    chk("idle flush inst", inst[0], 32'h0);
    chk("idle flush valid", {31'h0, vld[0]}, 32'h0);

    // Reset asserted in the middle of the write-enable pulse.
    ce[0] = 1'b1; op[0] = 1'b1; addr[0] = 32'h8000_0020; wd[0] = 32'h55AA_0FF0;
    cyc();
    ce[0] = 1'b0;
    cyc();
    chk("pulse we_n before reset", {31'h0, wen[0]}, 32'h0);
    rst = 1'b0;
    cyc();
    chk("midreset ctl", {23'h0, ctl(0)}, {23'h0, 9'b0_1110_1111});
    chk("midreset addr", {12'h0, saddr[0]}, 32'h0);
    chk("midreset wdata", sdo[0], 32'h0);
    chk("midreset inst", inst[0], 32'h0);
    chk("midreset valid", {31'h0, vld[0]}, 32'h0);
    rst = 1'b1;
    ref_mem[0][8] = 32'h55AA_0FF0;
    cyc();
    xact(0, 1'b0, 32'h8000_0020, 32'h0, -1, 0, 1'b0, 32'h55AA_0FF0, 1'b1, 20'h00008);

    // Random transactions against the reference memory.
    for (int r = 0; r < 80; r++) begin
      d    = int'($urandom_range(0, 1));
      wr   = ($urandom_range(0, 9) < 3);
      a    = $urandom;
      w    = $urandom;
      busy = wr ? ww(d) + 2 : rw(d);
      fc   = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, busy - 1)) : -1;
      sn   = int'($urandom_range(0, 3));
      dfl  = ($urandom_range(0, 9) == 0);
      idx  = int'((a >> 2) % 1024);
      if (wr)
        xact(d, 1'b1, a, w, fc, sn, dfl, 32'h0, 1'b0, 20'((a >> 2) % (1 << 20)));
      else
        xact(d, 1'b0, a, w, fc, sn, dfl, (fc >= 0) ? 32'h0 : ref_mem[d][idx], (fc < 0),
             20'((a >> 2) % (1 << 20)));
      if (wr) ref_mem[d][idx] = w;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
